// File: rtl/cache_pkg.sv
// Shared definitions for the trace request sequencer and its cache-side channel.
package cache_pkg;

    localparam int ADDR_W = 20;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_RESP,
        DONE
    } seq_state_e;

endpackage

// File: rtl/trace_request_sequencer_if.sv
// Cache request/response channel: one valid/ready request, one-cycle response strobe.
interface trace_request_sequencer_if
    import cache_pkg::*;
;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_op;
    logic              resp_valid;
    logic              resp_hit;

    // Sequencer side
    modport master (
        output req_valid, req_addr, req_op,
        input  req_ready, resp_valid, resp_hit
    );

    // Cache side
    modport slave (
        input  req_valid, req_addr, req_op,
        output req_ready, resp_valid, resp_hit
    );

endinterface

// File: rtl/trace_request_sequencer_stat_counters.sv
// Saturating hit/miss/read/write counters, updated once per accepted cache response.
module trace_stat_counters
    import cache_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             upd,
    input  logic             hit,
    input  op_e              op,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);

    logic [CNT_W-1:0] hit_q, hit_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic [CNT_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] wr_q, wr_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Next counter values: clear on run start, otherwise bump on each accepted response
    always_comb begin
        hit_d  = hit_q;
        miss_d = miss_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        if (clear) begin
            hit_d  = '0;
            miss_d = '0;
            rd_d   = '0;
            wr_d   = '0;
        end else if (upd) begin
            if (hit) hit_d  = sat_inc(hit_q);
            else     miss_d = sat_inc(miss_q);
            if (op == OP_READ) rd_d = sat_inc(rd_q);
            else               wr_d = sat_inc(wr_q);
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= '0;
            miss_q <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
    assign rd_cnt   = rd_q;
    assign wr_cnt   = wr_q;

endmodule

// File: rtl/trace_request_sequencer.sv
// Walks the trace table one entry at a time, issuing each entry to the cache and
// waiting for its response before fetching the next. One request outstanding max.
// Optional feature macro: TRACE_STATS_EN adds hit/miss/read/write statistics ports.
module trace_request_sequencer
    import cache_pkg::*;
#(
    parameter int NUM_INSTR = 524,
    parameter int IDX_W     = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [IDX_W-1:0]         trace_idx,
    input  logic [ADDR_W-1:0]        trace_addr,
    input  logic                     trace_op,
    trace_request_sequencer_if.master cache,
    output logic                     busy,
    output logic                     done,
    output logic [IDX_W:0]           issued_cnt,
    output logic                     err_resp
`ifdef TRACE_STATS_EN
    ,
    output logic [CNT_W-1:0]         hit_cnt,
    output logic [CNT_W-1:0]         miss_cnt,
    output logic [CNT_W-1:0]         rd_cnt,
    output logic [CNT_W-1:0]         wr_cnt
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INSTR - 1);

    if (NUM_INSTR < 1 || CNT_W < 1) begin : g_param_check
        $error("trace_request_sequencer: NUM_INSTR and CNT_W must be positive");
    end

    seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    op_e               req_op_q, req_op_d;
    logic [IDX_W:0]    issued_q, issued_d;
    logic              err_q, err_d;
    logic              run_clear;
    logic              resp_accept;

    // Next-state, index, captured request and run bookkeeping
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        req_addr_d  = req_addr_q;
        req_op_d    = req_op_q;
        issued_d    = issued_q;
        err_d       = err_q;
        run_clear   = 1'b0;
        resp_accept = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = FETCH;
                    idx_d     = '0;
                    issued_d  = '0;
                    err_d     = 1'b0;
                    run_clear = 1'b1;
                end
            end
            FETCH: begin
                // trace_addr/trace_op reflect idx by the end of FETCH
                state_d    = ISSUE;
                req_addr_d = trace_addr;
                req_op_d   = op_e'(trace_op);
            end
            ISSUE: begin
                if (cache.req_ready) begin
                    state_d = WAIT_RESP;
                    if (issued_q != '1) issued_d = issued_q + (IDX_W+1)'(1);
                end
            end
            WAIT_RESP: begin
                if (cache.resp_valid) begin
                    resp_accept = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A stray response (including one in the handshake cycle) is flagged, never counted
        if (cache.resp_valid && (state_q != WAIT_RESP)) err_d = 1'b1;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            req_addr_q <= '0;
            req_op_q   <= OP_WRITE;
            issued_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            req_addr_q <= req_addr_d;
            req_op_q   <= req_op_d;
            issued_q   <= issued_d;
            err_q      <= err_d;
        end
    end

    // Outputs decoded from the registered state so reset drops them immediately
    always_comb begin
        busy            = (state_q == FETCH) || (state_q == ISSUE) || (state_q == WAIT_RESP);
        done            = (state_q == DONE);
        cache.req_valid = (state_q == ISSUE);
        cache.req_addr  = req_addr_q;
        cache.req_op    = req_op_q;
        trace_idx       = idx_q;
        issued_cnt      = issued_q;
        err_resp        = err_q;
    end

`ifdef TRACE_STATS_EN
    trace_stat_counters #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (run_clear),
        .upd      (resp_accept),
        .hit      (cache.resp_hit),
        .op       (req_op_q),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt),
        .rd_cnt   (rd_cnt),
        .wr_cnt   (wr_cnt)
    );
`else
    logic stats_unused;
    assign stats_unused = ^{cache.resp_hit, run_clear, resp_accept};
`endif

endmodule

// File: tb/tb_trace_request_sequencer.sv
// Self-checking bench for trace_request_sequencer (NUM_INSTR = 4).
// Statistics checks are compiled in when TRACE_STATS_EN is defined.
`timescale 1ns/1ps
module tb_trace_request_sequencer;
    import cache_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int CW = 16;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              op;
        logic              hit;
        int                ready_wait;
        int                resp_wait;
        bit                pulse_hs;
        bit                start_busy;
        int                exp_cycles;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [IW-1:0]     trace_idx;
    logic [ADDR_W-1:0] trace_addr;
    logic              trace_op;
    logic              busy, done, err_resp;
    logic [IW:0]       issued_cnt;
`ifdef TRACE_STATS_EN
    logic [CW-1:0]     hit_cnt, miss_cnt, rd_cnt, wr_cnt;
`endif

    logic [ADDR_W-1:0] mem_addr [N];
    logic              mem_op   [N];
    ent_t              tbl [2*N];
    ent_t              cur [N];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busy_cyc = 0;

    trace_request_sequencer_if cache();

    trace_request_sequencer #(
        .NUM_INSTR (N),
        .IDX_W     (IW),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .trace_idx  (trace_idx),
        .trace_addr (trace_addr),
        .trace_op   (trace_op),
        .cache      (cache),
        .busy       (busy),
        .done       (done),
        .issued_cnt (issued_cnt),
        .err_resp   (err_resp)
`ifdef TRACE_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt),
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt)
`endif
    );

    assign trace_addr = mem_addr[trace_idx];
    assign trace_op   = mem_op[trace_idx];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request must hold address/op while waiting for ready
    logic              prev_valid = 1'b0, prev_ready = 1'b0, prev_op = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    always @(negedge clk) begin
        if (busy) busy_cyc++;
        if (rst_n && prev_valid && !prev_ready && cache.req_valid) begin
            check("req_hold_addr", 32'(cache.req_addr), 32'(prev_addr));
            check("req_hold_op", 32'(cache.req_op), 32'(prev_op));
        end
        prev_valid = cache.req_valid;
        prev_ready = cache.req_ready;
        prev_addr  = cache.req_addr;
        prev_op    = cache.req_op;
    end

    // Act as the cache for one trace entry
    task automatic serve(input int i, input ent_t e);
        int n;
        n = 0;
        while (!cache.req_valid && n < 20) begin
            tick();
            n++;
        end
        if (!cache.req_valid) begin
            checks++;
            failures++;
            $display("FAIL req_valid_timeout: got 0 expected 1 (entry %0d)", i);
            return;
        end
        check("issue_idx", 32'(trace_idx), 32'(i));
        for (int w = 0; w < e.ready_wait; w++) begin
            start = (e.start_busy && w == 0);
            tick();
            start = 1'b0;
        end
        check("hold_valid", 32'(cache.req_valid), 32'd1);
        check("hold_idx", 32'(trace_idx), 32'(i));
        check("req_addr", 32'(cache.req_addr), 32'(e.addr));
        check("req_op", 32'(cache.req_op), 32'(e.op));
        cache.req_ready  = 1'b1;
        cache.resp_valid = e.pulse_hs;
        cache.resp_hit   = ~e.hit;
        tick();
        cache.req_ready  = 1'b0;
        cache.resp_valid = 1'b0;
        check("issued_cnt", 32'(issued_cnt), 32'(i + 1));
        check("valid_drop", 32'(cache.req_valid), 32'd0);
        if (e.pulse_hs) check("err_hs", 32'(err_resp), 32'd1);
        repeat (e.resp_wait) tick();
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_idx", 32'(trace_idx), 32'(i));
        cache.resp_valid = 1'b1;
        cache.resp_hit   = e.hit;
        tick();
        cache.resp_valid = 1'b0;
    endtask

    // Full run over cur[], checked against trace-order and per-run totals
    task automatic run_trace();
        int c_prev, b0, tot, hits, rds;
        bit any_err;
        for (int i = 0; i < N; i++) begin
            mem_addr[i] = cur[i].addr;
            mem_op[i]   = cur[i].op;
        end
        b0 = busy_cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_done", 32'(done), 32'd0);
        check("start_idx", 32'(trace_idx), 32'd0);
        check("start_issued", 32'(issued_cnt), 32'd0);
        check("start_err", 32'(err_resp), 32'd0);
        c_prev = cyc;
        tot = 0; hits = 0; rds = 0; any_err = 1'b0;
        for (int i = 0; i < N; i++) begin
            serve(i, cur[i]);
            check("entry_cycles", 32'(cyc - c_prev), 32'(cur[i].exp_cycles));
            c_prev = cyc;
            tot += cur[i].exp_cycles;
            hits += int'(cur[i].hit);
            rds += int'(cur[i].op);
            any_err |= cur[i].pulse_hs;
        end
        check("end_done", 32'(done), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_issued", 32'(issued_cnt), 32'(N));
        check("end_idx", 32'(trace_idx), 32'(N - 1));
        check("end_err", 32'(err_resp), 32'(any_err));
        check("busy_cycles", 32'(busy_cyc - b0), 32'(tot));
`ifdef TRACE_STATS_EN
        check("hit_cnt", 32'(hit_cnt), 32'(hits));
        check("miss_cnt", 32'(miss_cnt), 32'(N - hits));
        check("rd_cnt", 32'(rd_cnt), 32'(rds));
        check("wr_cnt", 32'(wr_cnt), 32'(N - rds));
`endif
        repeat (2) tick();
        check("done_held", 32'(done), 32'd1);
    endtask

    initial begin
        // addr, op, hit, ready_wait, resp_wait, pulse_hs, start_busy, exp_cycles
        tbl[0] = '{20'h01234, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 3};
        tbl[1] = '{20'h05678, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 3};
        tbl[2] = '{20'h09abc, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 3};
        tbl[3] = '{20'h0def0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 3};
        tbl[4] = '{20'habcde, 1'b0, 1'b1, 0, 3, 1'b0, 1'b0, 6};
        tbl[5] = '{20'h00001, 1'b1, 1'b0, 5, 0, 1'b0, 1'b0, 8};
        tbl[6] = '{20'hfffff, 1'b1, 1'b1, 0, 2, 1'b1, 1'b0, 5};
        tbl[7] = '{20'h80000, 1'b0, 1'b0, 1, 1, 1'b0, 1'b1, 5};
        for (int i = 0; i < N; i++) begin
            mem_addr[i] = '0;
            mem_op[i]   = 1'b0;
        end
        cache.req_ready  = 1'b0;
        cache.resp_valid = 1'b0;
        cache.resp_hit   = 1'b0;

        // Reset state
        #22;
        check("rst_req_valid", 32'(cache.req_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_idx", 32'(trace_idx), 32'd0);
        check("rst_issued", 32'(issued_cnt), 32'd0);
        check("rst_err", 32'(err_resp), 32'd0);
        check("rst_req_addr", 32'(cache.req_addr), 32'd0);
`ifdef TRACE_STATS_EN
        check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Stray response while idle: flagged, FSM stays idle
        cache.resp_valid = 1'b1;
        tick();
        cache.resp_valid = 1'b0;
        check("idle_err", 32'(err_resp), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        // Table-driven runs
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) cur[i] = tbl[r*N + i];
            run_trace();
        end

        // Reset during WAIT_RESP of entry 2, then rerun from entry 0
        for (int i = 0; i < N; i++) cur[i] = tbl[i];
        for (int i = 0; i < N; i++) begin
            mem_addr[i] = cur[i].addr;
            mem_op[i]   = cur[i].op;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        serve(0, cur[0]);
        serve(1, cur[1]);
        tick();
        cache.req_ready = 1'b1;
        tick();
        cache.req_ready = 1'b0;
        check("pre_rst_idx", 32'(trace_idx), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check("arst_req_valid", 32'(cache.req_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_idx", 32'(trace_idx), 32'd0);
        check("arst_issued", 32'(issued_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_valid", 32'(cache.req_valid), 32'd0);
        run_trace();

        // Randomized runs against the reference rules
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                cur[i].addr       = ADDR_W'($urandom);
                cur[i].op         = 1'($urandom_range(0, 1));
                cur[i].hit        = 1'($urandom_range(0, 1));
                cur[i].ready_wait = int'($urandom_range(0, 3));
                cur[i].resp_wait  = int'($urandom_range(0, 3));
                cur[i].pulse_hs   = ($urandom_range(0, 3) == 0);
                cur[i].start_busy = (cur[i].ready_wait > 0) && ($urandom_range(0, 1) == 1);
                cur[i].exp_cycles = 3 + cur[i].ready_wait + cur[i].resp_wait;
            end
            run_trace();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
